// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matmul fetch-injection block.
package matmul_pkg;

  localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;
  localparam logic [31:0] NOP         = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/matmul_trigger_detect.sv
// Flags a custom-0 instruction whose funct3 selects the MATMUL trigger.
module matmul_trigger_detect
  import matmul_pkg::*;
#(
  parameter logic [2:0] TRIG_FUNCT3 = 3'b000
) (
  input  logic [31:0] instr,
  output logic        is_trigger
);

  // Only opcode and funct3 matter; the remaining fields are deliberately ignored.
  logic unused_fields;

  assign unused_fields = ^{instr[31:15], instr[11:7]};
  assign is_trigger    = (instr[6:0] == OPC_CUSTOM0) && (instr[14:12] == TRIG_FUNCT3);

endmodule

// File: rtl/matmul_fetch_inject.sv
// Fetch-stage mux that hands the IF/ID slot to the matmul sequencer on a
// custom-0 trigger and returns it to the CPU when the program ends.
module matmul_fetch_inject
  import matmul_pkg::*;
#(
  parameter logic [2:0]  TRIG_FUNCT3 = 3'b000,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_f,
  input  logic                 stall_f,
  input  logic                 flush_d,
  input  logic [31:0]          mm_instr,
  input  logic                 mm_done,
  output logic                 mm_start,
  output logic                 mm_stall,
  output logic [31:0]          instr_out,
  output logic                 pc_hold,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] run_cycles
);

  state_e               state_q, state_d, state_cur;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
  logic                 trig_f, trig_mm;

  matmul_trigger_detect #(.TRIG_FUNCT3(TRIG_FUNCT3)) u_trig_f (
    .instr      (instr_f),
    .is_trigger (trig_f)
  );

  matmul_trigger_detect #(.TRIG_FUNCT3(TRIG_FUNCT3)) u_trig_mm (
    .instr      (mm_instr),
    .is_trigger (trig_mm)
  );

  // Reset forces IDLE decoding so the outputs are quiet in the reset cycle itself.
  always_comb begin
    state_cur    = rst ? ST_IDLE : state_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    instr_out    = instr_f;
    pc_hold      = 1'b0;
    mm_start     = 1'b0;
    mm_stall     = 1'b1;
    busy         = 1'b0;

    case (state_cur)
      ST_IDLE: begin
        if (trig_f) begin
          instr_out = NOP;
          if (!stall_f && !flush_d) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
      end

      ST_START: begin
        instr_out = NOP;
        mm_start  = 1'b1;
        pc_hold   = 1'b1;
        busy      = 1'b1;
        cnt_d     = '0;
        state_d   = flush_d ? ST_IDLE : ST_STREAM;
      end

      ST_STREAM: begin
        pc_hold   = 1'b1;
        busy      = 1'b1;
        mm_stall  = stall_f;
        instr_out = (mm_done || trig_mm) ? NOP : mm_instr;
        // Flush wins over end-of-program; a stall freezes everything else.
        if (flush_d) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!stall_f) begin
          if (mm_done) begin
            run_cycles_d = cnt_q;
            state_d      = ST_IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles = run_cycles_q;

endmodule
